counter_seq_checker: RTL and testbench
======================================

// Module: counter_seq_checker
// PURPOSE
//  Downstream monitor for the 4-bit debug counter. Samples the counter value
//  (dout) each qualified cycle, locks onto the +1 (mod 2^WIDTH) sequence,
//  then flags any skip, stall or jump and counts wrap-arounds. Feeds debug
//  LEDs / ILA probes with error and lock status.
// PARAMETERS
//  WIDTH       4   width of monitored count value
//  SYNC_LEN    2   consecutive good increments required to enter LOCKED (>=1)
//  ERR_CNT_W   8   width of saturating error counter
//  WRAP_CNT_W  16  width of saturating wrap counter
// PORTS
//  clk         in   1           rising-edge clock, same domain as counter
//  reset       in   1           synchronous, active-high
//  din_valid   in   1           1 = sample din this cycle
//  din         in   WIDTH       monitored count value
//  clr_err     in   1           clear err_sticky and err_count
//  locked      out  1           1 = FSM in LOCKED
//  err_pulse   out  1           one-cycle pulse per detected mismatch
//  err_sticky  out  1           set on mismatch, held until clr_err/reset
//  err_count   out  ERR_CNT_W   saturating mismatch count
//  wrap_count  out  WRAP_CNT_W  saturating count of (2^WIDTH-1)->0 in LOCKED
//  exp_value   out  WIDTH       expected value at last mismatch
//  bad_value   out  WIDTH       received value at last mismatch
// BEHAVIOUR
//  - Reset: state=UNLOCKED; all outputs 0; internal prev=0, good_cnt=0.
//  - All outputs registered; update on edge that samples din. din_valid=0:
//    state, prev, counters hold; err_pulse=0.
//  - expected = prev + 1, truncated to WIDTH bits (15->0 is a good increment).
//  - UNLOCKED: valid sample -> prev=din, good_cnt=0, go SYNC. No checking.
//  - SYNC: valid & din==expected -> good_cnt+1; when new good_cnt==SYNC_LEN
//    go LOCKED, good_cnt=0. Valid & mismatch -> good_cnt=0, stay SYNC,
//    no error reported. prev=din on every valid sample.
//  - LOCKED: valid & match -> prev=din; if prev=all-ones and din=0,
//    wrap_count+1 (saturate at all-ones). Valid & mismatch -> err_pulse=1
//    for that one cycle, err_sticky=1, err_count+1 (saturate),
//    exp_value=expected, bad_value=din, prev=din, good_cnt=0, go SYNC.
//  - locked = (state==LOCKED); drops on the edge that detects a mismatch.
//  - Upstream counter reset while LOCKED is a genuine discontinuity and is
//    reported as an error (exp=n+1, bad=0).
//  - clr_err: next edge err_sticky=0, err_count=0. Simultaneous with a
//    mismatch: mismatch wins for sticky (=1) and count restarts at 1.
//    clr_err does not touch wrap_count, exp_value, bad_value, state.
//  - reset mid-operation overrides everything, incl. a coincident mismatch.
// TESTING
//  1. reset, din=0,1,2.. valid every cycle -> locked=1 after edge sampling
//     din=2; after 15->0 wrap_count=1; err_count stays 0.
//  2. Locked, inject 5,6,8,9,10 -> err_pulse 1 cycle on 8, exp_value=7,
//     bad_value=8, err_count=1, locked=0; relocks after sampling 10.
//  3. Locked, din_valid toggled 1/0 with din held during gaps -> no error,
//     outputs hold through gaps, wrap_count still increments on 15->0.
//  4. ERR_CNT_W=2, force 5 mismatches -> err_count saturates at 3;
//     WRAP_CNT_W=2 with 5 wraps -> wrap_count=3.
//  5. clr_err on same edge as a mismatch -> err_sticky=1, err_count=1;
//     clr_err alone later -> err_sticky=0, err_count=0, wrap_count unchanged.
//  6. reset asserted while locked and on a mismatch edge -> next cycle all
//     outputs 0, state UNLOCKED; sequence 3,4,5 then relocks.

Source files
------------

// File: rtl/counter_seq_checker_if.sv
// Monitor bus for counter_seq_checker: sampled count value in, lock/error status out.
// The master side owns the sample stream and error clear; the slave side is the checker.
interface counter_seq_checker_if #(
    parameter int WIDTH      = 4,
    parameter int ERR_CNT_W  = 8,
    parameter int WRAP_CNT_W = 16
) ();
    logic                  din_valid;
    logic [WIDTH-1:0]      din;
    logic                  clr_err;
    logic                  locked;
    logic                  err_pulse;
    logic                  err_sticky;
    logic [ERR_CNT_W-1:0]  err_count;
    logic [WRAP_CNT_W-1:0] wrap_count;
    logic [WIDTH-1:0]      exp_value;
    logic [WIDTH-1:0]      bad_value;

    modport master (
        output din_valid, din, clr_err,
        input  locked, err_pulse, err_sticky, err_count, wrap_count, exp_value, bad_value
    );

    modport slave (
        input  din_valid, din, clr_err,
        output locked, err_pulse, err_sticky, err_count, wrap_count, exp_value, bad_value
    );
endinterface

// File: rtl/counter_seq_checker.sv
// Locks onto a +1 (mod 2^WIDTH) count stream, then flags skips/stalls/jumps and counts wraps.
// Latency: all status registered, visible the cycle after the sampling edge.
// Backpressure: none; din_valid=0 cycles are ignored and all state holds.
module counter_seq_checker #(
    parameter int WIDTH      = 4,
    parameter int SYNC_LEN   = 2,
    parameter int ERR_CNT_W  = 8,
    parameter int WRAP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    counter_seq_checker_if.slave  mon
);
    localparam int GC_W = (SYNC_LEN < 2) ? 1 : $clog2(SYNC_LEN + 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_SYNC     = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    state_t                state_q,      state_d;
    logic [WIDTH-1:0]      prev_q,       prev_d;
    logic [GC_W-1:0]       good_cnt_q,   good_cnt_d;
    logic                  err_pulse_q,  err_pulse_d;
    logic                  err_sticky_q, err_sticky_d;
    logic [ERR_CNT_W-1:0]  err_count_q,  err_count_d;
    logic [WRAP_CNT_W-1:0] wrap_count_q, wrap_count_d;
    logic [WIDTH-1:0]      exp_value_q,  exp_value_d;
    logic [WIDTH-1:0]      bad_value_q,  bad_value_d;

    logic [WIDTH-1:0] expected;
    logic             sample_match;
    logic [GC_W-1:0]  good_cnt_inc;
    logic             mismatch_det;

    assign expected     = prev_q + WIDTH'(1);
    assign sample_match = (mon.din == expected);
    assign good_cnt_inc = good_cnt_q + GC_W'(1);

    // Sequence tracking FSM: next state, prev sample, sync progress, wrap and capture regs.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        good_cnt_d   = good_cnt_q;
        err_pulse_d  = 1'b0;
        wrap_count_d = wrap_count_q;
        exp_value_d  = exp_value_q;
        bad_value_d  = bad_value_q;
        mismatch_det = 1'b0;

        if (mon.din_valid) begin
            prev_d = mon.din;
            case (state_q)
                ST_UNLOCKED: begin
                    state_d    = ST_SYNC;
                    good_cnt_d = '0;
                end
                ST_SYNC: begin
                    if (!sample_match) begin
                        good_cnt_d = '0;
                    end else if (good_cnt_inc == GC_W'(SYNC_LEN)) begin
                        state_d    = ST_LOCKED;
                        good_cnt_d = '0;
                    end else begin
                        good_cnt_d = good_cnt_inc;
                    end
                end
                ST_LOCKED: begin
                    if (sample_match) begin
                        // A matching sample with prev at all-ones is exactly the wrap to zero.
                        if ((prev_q == '1) && (wrap_count_q != '1)) begin
                            wrap_count_d = wrap_count_q + WRAP_CNT_W'(1);
                        end
                    end else begin
                        mismatch_det = 1'b1;
                        err_pulse_d  = 1'b1;
                        exp_value_d  = expected;
                        bad_value_d  = mon.din;
                        good_cnt_d   = '0;
                        state_d      = ST_SYNC;
                    end
                end
                default: begin
                    state_d    = ST_UNLOCKED;
                    good_cnt_d = '0;
                end
            endcase
        end
    end

    // Error bookkeeping: a mismatch beats a coincident clear, and the count restarts at one.
    always_comb begin
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;
        if (mismatch_det) begin
            err_sticky_d = 1'b1;
            if (mon.clr_err) begin
                err_count_d = ERR_CNT_W'(1);
            end else if (err_count_q != '1) begin
                err_count_d = err_count_q + ERR_CNT_W'(1);
            end
        end else if (mon.clr_err) begin
            err_sticky_d = 1'b0;
            err_count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_UNLOCKED;
            prev_q       <= '0;
            good_cnt_q   <= '0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
            wrap_count_q <= '0;
            exp_value_q  <= '0;
            bad_value_q  <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            good_cnt_q   <= good_cnt_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
            wrap_count_q <= wrap_count_d;
            exp_value_q  <= exp_value_d;
            bad_value_q  <= bad_value_d;
        end
    end

    assign mon.locked     = (state_q == ST_LOCKED);
    assign mon.err_pulse  = err_pulse_q;
    assign mon.err_sticky = err_sticky_q;
    assign mon.err_count  = err_count_q;
    assign mon.wrap_count = wrap_count_q;
    assign mon.exp_value  = exp_value_q;
    assign mon.bad_value  = bad_value_q;
endmodule

// File: tb/tb_counter_seq_checker.sv
// Directed and random stimulus for counter_seq_checker, checked against a behavioural model.
// A second instance with 2-bit counters shares the same stimulus to exercise saturation.
module tb_counter_seq_checker;
    localparam int SYNC_LEN = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       din_valid;
    logic [3:0] din;
    logic       clr_err;

    int checks   = 0;
    int failures = 0;

    counter_seq_checker_if #(.WIDTH(4), .ERR_CNT_W(8), .WRAP_CNT_W(16)) bus_a ();
    counter_seq_checker_if #(.WIDTH(4), .ERR_CNT_W(2), .WRAP_CNT_W(2))  bus_b ();

    assign bus_a.din_valid = din_valid;
    assign bus_a.din       = din;
    assign bus_a.clr_err   = clr_err;
    assign bus_b.din_valid = din_valid;
    assign bus_b.din       = din;
    assign bus_b.clr_err   = clr_err;

    counter_seq_checker #(.WIDTH(4), .SYNC_LEN(SYNC_LEN), .ERR_CNT_W(8), .WRAP_CNT_W(16)) dut_a (
        .clk   (clk),
        .reset (reset),
        .mon   (bus_a)
    );

    counter_seq_checker #(.WIDTH(4), .SYNC_LEN(SYNC_LEN), .ERR_CNT_W(2), .WRAP_CNT_W(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .mon   (bus_b)
    );

    always #5 clk = ~clk;

    // Behavioural model: raw unbounded counts, saturated per instance at comparison time.
    bit m_seen, m_locked, m_pulse, m_sticky;
    int m_prev, m_run, m_errs, m_wraps, m_exp, m_bad;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_seen = 0; m_locked = 0; m_pulse = 0; m_sticky = 0;
        m_prev = 0; m_run = 0; m_errs = 0; m_wraps = 0; m_exp = 0; m_bad = 0;
    endtask

    task automatic model_step(input bit v, input int d, input bit c, input bit r);
        bit err_now;
        int nxt;
        if (r) begin
            model_reset();
            return;
        end
        err_now = 0;
        m_pulse = 0;
        if (v) begin
            nxt = (m_prev + 1) % 16;
            if (!m_seen) begin
                m_seen = 1;
                m_run  = 0;
            end else if (m_locked) begin
                if (d == nxt) begin
                    if (d == 0) m_wraps++;
                end else begin
                    err_now  = 1;
                    m_pulse  = 1;
                    m_exp    = nxt;
                    m_bad    = d;
                    m_locked = 0;
                    m_run    = 0;
                end
            end else if (d == nxt) begin
                m_run++;
                if (m_run == SYNC_LEN) begin
                    m_locked = 1;
                    m_run    = 0;
                end
            end else begin
                m_run = 0;
            end
            m_prev = d;
        end
        if (err_now) begin
            m_sticky = 1;
            m_errs   = c ? 1 : m_errs + 1;
        end else if (c) begin
            m_sticky = 0;
            m_errs   = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("a.locked",     32'(bus_a.locked),     32'(m_locked));
        chk("a.err_pulse",  32'(bus_a.err_pulse),  32'(m_pulse));
        chk("a.err_sticky", 32'(bus_a.err_sticky), 32'(m_sticky));
        chk("a.err_count",  32'(bus_a.err_count),  sat(m_errs, 255));
        chk("a.wrap_count", 32'(bus_a.wrap_count), sat(m_wraps, 65535));
        chk("a.exp_value",  32'(bus_a.exp_value),  m_exp);
        chk("a.bad_value",  32'(bus_a.bad_value),  m_bad);
        chk("b.locked",     32'(bus_b.locked),     32'(m_locked));
        chk("b.err_count",  32'(bus_b.err_count),  sat(m_errs, 3));
        chk("b.wrap_count", 32'(bus_b.wrap_count), sat(m_wraps, 3));
    endtask

    int cur;

    // Drive one cycle's inputs, let the edge happen, then compare 1 time unit later.
    task automatic cycle(input bit v, input int d, input bit c, input bit r);
        din_valid = v;
        din       = 4'(d);
        clr_err   = c;
        reset     = r;
        @(posedge clk);
        model_step(v, d, c, r);
        #1;
        check_all();
    endtask

    task automatic count_up(input int n);
        for (int k = 0; k < n; k++) begin
            cur = (cur + 1) % 16;
            cycle(1, cur, 0, 0);
        end
    endtask

    initial begin
        din_valid = 0; din = 0; clr_err = 0; reset = 1;
        model_reset();

        // Reset state
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        chk("rst_locked", 32'(bus_a.locked), 0);
        chk("rst_errcnt", 32'(bus_a.err_count), 0);

        // Lock on 0,1,2 and run through a wrap
        cur = 0;
        cycle(1, 0, 0, 0);
        count_up(1);
        chk("t1_pre_lock", 32'(bus_a.locked), 0);
        count_up(1);
        chk("t1_locked", 32'(bus_a.locked), 1);
        count_up(18);
        chk("t1_wrap", 32'(bus_a.wrap_count), 1);
        chk("t1_noerr", 32'(bus_a.err_count), 0);

        // Skip 7: error on 8, relock after 10
        cycle(1, 5, 0, 0);
        cycle(1, 6, 0, 0);
        cycle(1, 8, 0, 0);
        chk("t2_pulse", 32'(bus_a.err_pulse), 1);
        chk("t2_exp", 32'(bus_a.exp_value), 7);
        chk("t2_bad", 32'(bus_a.bad_value), 8);
        chk("t2_cnt", 32'(bus_a.err_count), 1);
        chk("t2_unlock", 32'(bus_a.locked), 0);
        cycle(1, 9, 0, 0);
        chk("t2_pulse_off", 32'(bus_a.err_pulse), 0);
        cycle(1, 10, 0, 0);
        chk("t2_relock", 32'(bus_a.locked), 1);
        cur = 10;

        // Valid gaps with din held
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin
                cur = (cur + 1) % 16;
                cycle(1, cur, 0, 0);
            end else begin
                cycle(0, cur, 0, 0);
            end
        end
        chk("t3_wrap", 32'(bus_a.wrap_count), 2);
        chk("t3_cnt", 32'(bus_a.err_count), 1);

        // Clear coincident with mismatch, then clear alone
        cycle(1, (cur + 3) % 16, 1, 0);
        chk("t5_sticky", 32'(bus_a.err_sticky), 1);
        chk("t5_cnt", 32'(bus_a.err_count), 1);
        cur = (cur + 3) % 16;
        count_up(2);
        cycle(0, cur, 1, 0);
        chk("t5_clr_sticky", 32'(bus_a.err_sticky), 0);
        chk("t5_clr_cnt", 32'(bus_a.err_count), 0);
        chk("t5_wrap_kept", 32'(bus_a.wrap_count), 2);

        // Saturation on the narrow instance
        for (int i = 0; i < 5; i++) begin
            count_up(3);
            cur = (cur + 5) % 16;
            cycle(1, cur, 0, 0);
        end
        chk("t4_errsat_b", 32'(bus_b.err_count), 3);
        chk("t4_err_a", 32'(bus_a.err_count), 5);
        count_up(2);
        count_up(80);
        chk("t4_wrapsat_b", 32'(bus_b.wrap_count), 3);

        // Reset on a mismatch edge while locked, then relock on 3,4,5
        cycle(1, (cur + 7) % 16, 0, 1);
        chk("t6_locked", 32'(bus_a.locked), 0);
        chk("t6_pulse", 32'(bus_a.err_pulse), 0);
        chk("t6_wrap", 32'(bus_a.wrap_count), 0);
        cycle(1, 3, 0, 0);
        cycle(1, 4, 0, 0);
        cycle(1, 5, 0, 0);
        chk("t6_relock", 32'(bus_a.locked), 1);
        cur = 5;

        // Random traffic: mostly good increments, occasional jumps, clears and resets
        for (int i = 0; i < 600; i++) begin
            bit v, c, r;
            int d;
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 24) == 0);
            r = ($urandom_range(0, 149) == 0);
            if (v) begin
                d = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 15)) : (cur + 1) % 16;
                cur = d;
            end else begin
                d = int'($urandom_range(0, 15));
            end
            cycle(v, d, c, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
